router_input_channel: RTL and testbench
=======================================

ROUTER_INPUT_CHANNEL -- requirements
Module: router_input_channel

Interface
REQ-001 Parameter FLIT_W, default 64, flit width in bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-low reset (asserted when 0).
REQ-004 polarity  input  1  network phase; toggles every cycle; selects the write buffer and the read buffer.
REQ-005 send  input  1  upstream presents a flit on data_in this cycle.
REQ-006 blocked  input  1  downstream cannot accept a flit this cycle.
REQ-007 data_in  input  FLIT_W  flit from upstream.
REQ-008 ready  output  1  write-side buffer is empty; a flit offered with send will be accepted.
REQ-009 data_out  output  FLIT_W  registered flit to the output channel; all-zero when idle.

Function
REQ-010 The block SHALL hold two FLIT_W-bit buffers, buf[0] (even) and buf[1] (odd), each with a valid bit.
REQ-011 Write side SHALL be buf[polarity]; read side SHALL be buf[~polarity].
REQ-012 ready SHALL be combinational: ready = !valid[polarity].
REQ-013 On a rising edge with send=1 and ready=1, buf[polarity] SHALL load data_in and set valid[polarity]=1.
REQ-014 send=1 with ready=0 SHALL be ignored; the buffer contents are unchanged and the flit is dropped (upstream must gate send with ready).
REQ-015 On a rising edge with valid[~polarity]=1 and blocked=0, data_out SHALL load buf[~polarity] and valid[~polarity] SHALL clear.
REQ-016 On any other rising edge, data_out SHALL load all-zero.
REQ-017 With blocked=1, the read-side buffer SHALL keep its flit and valid bit until a later edge where that buffer is on the read side and blocked=0.
REQ-018 Write and read act on different buffers, so both SHALL complete on the same edge without conflict.
REQ-019 Latency: a flit written at edge N with polarity=p SHALL appear on data_out after edge N+1 when polarity=~p at that edge and blocked=0.
REQ-020 If polarity does not toggle, the same buffer stays on the write side and the other stays on the read side; no other behaviour changes.
REQ-021 Data SHALL pass through unmodified; there is no header decode in this block.

Reset
REQ-022 While reset=0 at a rising edge, both valid bits SHALL clear, both buffers and data_out SHALL become zero, and send and blocked SHALL be ignored.
REQ-023 After reset, ready SHALL read 1.
REQ-024 A flit in flight when reset is asserted SHALL be discarded.

Structure
REQ-025 A shared package router_pkg SHALL hold FLIT_W (64) and the even/odd buffer index constants (EVEN=0, ODD=1).
REQ-026 One sub-module, channel_buffer, SHALL be instantiated twice; it holds one flit register and its valid bit and provides load and clear controls.
REQ-027 router_output_channel is a separately specified sibling block that consumes data_out; it is not part of this module.

Verification
REQ-028 Reset: hold reset=0 for 2 cycles, then release -> ready=1 and data_out=0 on the first cycle after release.
REQ-029 Single flit: polarity=0, send=1, data_in=0xfA50 -> after the next edge with polarity=1 and blocked=0, data_out=0xfA50; one cycle later data_out=0.
REQ-030 Stream: send flits 0xfA50, 0x6840, 0xffff and 0xc7d4 on consecutive cycles while polarity toggles -> each flit appears on data_out exactly once, in order, one cycle after its write, with no zero gaps between flits.
REQ-031 Block: write 0xffffffff on the even buffer, then hold blocked=1 for 3 cycles -> data_out stays 0, ready=0 whenever polarity=0, and data_out=0xffffffff at the first eligible edge after blocked drops.
REQ-032 Overflow: buffer occupied and send=1 -> ready=0, the new flit is dropped, and the original flit is delivered intact.
REQ-033 Mid-operation reset: both buffers full, then reset=0 for 1 edge -> data_out=0, ready=1, and neither old flit ever appears.

Source files
------------

// File: rtl/router_pkg.sv
// Shared constants for the router channel blocks.
// Flit width and even/odd double-buffer indices.
package router_pkg;

    localparam int FLIT_W = 64;

    localparam logic EVEN = 1'b0;
    localparam logic ODD  = 1'b1;

endpackage

// File: rtl/channel_buffer.sv
// One flit register with its valid bit.
// A load takes priority over a clear on the same edge.
module channel_buffer
    import router_pkg::*;
#(
    parameter int W = FLIT_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] data_in,
    output logic         valid,
    output logic [W-1:0] data
);

    always_ff @(posedge clk) begin
        if (!reset) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= data_in;
        end else if (clear) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/router_input_channel.sv
// Router input channel: even/odd double buffer steered by polarity.
// Upstream writes buf[polarity]; downstream drains buf[~polarity].
module router_input_channel
    import router_pkg::EVEN, router_pkg::ODD;
#(
    parameter int FLIT_W = router_pkg::FLIT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              polarity,
    input  logic              send,
    input  logic              blocked,
    input  logic [FLIT_W-1:0] data_in,
    output logic              ready,
    output logic [FLIT_W-1:0] data_out
);

    logic [1:0]        valid;
    logic [FLIT_W-1:0] data_even;
    logic [FLIT_W-1:0] data_odd;
    logic [FLIT_W-1:0] rd_data;
    logic              wr_en;
    logic              rd_en;

    assign ready = !valid[polarity];
    assign wr_en = send && ready;
    assign rd_en = valid[~polarity] && !blocked;

    assign rd_data = (polarity == EVEN) ? data_odd : data_even;

    channel_buffer #(.W(FLIT_W)) u_even (
        .clk     (clk),
        .reset   (reset),
        .load    (wr_en && (polarity == EVEN)),
        .clear   (rd_en && (polarity == ODD)),
        .data_in (data_in),
        .valid   (valid[0]),
        .data    (data_even)
    );

    channel_buffer #(.W(FLIT_W)) u_odd (
        .clk     (clk),
        .reset   (reset),
        .load    (wr_en && (polarity == ODD)),
        .clear   (rd_en && (polarity == EVEN)),
        .data_in (data_in),
        .valid   (valid[1]),
        .data    (data_odd)
    );

    // Output is zero on every edge that does not forward a flit.
    always_ff @(posedge clk) begin
        if (!reset) begin
            data_out <= '0;
        end else if (rd_en) begin
            data_out <= rd_data;
        end else begin
            data_out <= '0;
        end
    end

endmodule

// File: tb/tb_router_input_channel.sv
// Scoreboard bench for router_input_channel.
// Stimulus queues flits with their due edge; a monitor checks data_out.
module tb_router_input_channel;

    localparam int W = 64;

    logic         clk = 1'b0;
    logic         reset;
    logic         polarity;
    logic         send;
    logic         blocked;
    logic [W-1:0] data_in;
    logic         ready;
    logic [W-1:0] data_out;

    int cyc   = 0;
    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [W-1:0] val;
        int           at;
    } exp_t;

    exp_t sb[$];

    router_input_channel #(.FLIT_W(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .polarity (polarity),
        .send     (send),
        .blocked  (blocked),
        .data_in  (data_in),
        .ready    (ready),
        .data_out (data_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: data_out after edge cyc must match the flit due then, else zero.
    always @(negedge clk) begin
        exp_t e;
        if (cyc >= 1) begin
            while (sb.size() > 0 && sb[0].at < cyc) begin
                e = sb.pop_front();
                total++;
                bad++;
                $display("FAIL missing_flit due=%0d exp=%h", e.at, e.val);
            end
            total++;
            if (sb.size() > 0 && sb[0].at == cyc) begin
                e = sb.pop_front();
                if (data_out !== e.val) begin
                    bad++;
                    $display("FAIL flit edge=%0d got=%h exp=%h",
                             cyc, data_out, e.val);
                end
            end else if (data_out !== '0) begin
                bad++;
                $display("FAIL idle edge=%0d got=%h exp=0", cyc, data_out);
            end
        end
    end

    task automatic push_exp(input logic [W-1:0] v, input int at);
        exp_t e;
        e.val = v;
        e.at  = at;
        sb.push_back(e);
    endtask

    // Drive one cycle; rexp >= 0 checks ready before the edge.
    task automatic step(input int rst, input int pol, input int snd,
                        input int blk, input logic [W-1:0] d,
                        input int rexp);
        reset    = rst[0];
        polarity = pol[0];
        send     = snd[0];
        blocked  = blk[0];
        data_in  = d;
        #1;
        if (rexp >= 0) begin
            total++;
            if (ready !== rexp[0]) begin
                bad++;
                $display("FAIL ready edge=%0d got=%b exp=%0d",
                         cyc + 1, ready, rexp);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int pol, input int rexp);
        step(1, pol, 0, 0, '0, rexp);
    endtask

    task automatic check_zero_out(input string name);
        total++;
        if (data_out !== '0) begin
            bad++;
            $display("FAIL %s got=%h exp=0", name, data_out);
        end
    endtask

    initial begin
        logic [W-1:0] sv [4];
        sv[0] = 64'hfA50;
        sv[1] = 64'h6840;
        sv[2] = 64'hffff;
        sv[3] = 64'hc7d4;

        // Reset for two edges; send/blocked must be ignored.
        step(0, 0, 1, 1, 64'h1111, -1);
        step(0, 1, 1, 1, 64'h2222, -1);
        check_zero_out("reset_data_out");
        idle(0, 1);

        // Single flit.
        push_exp(64'hfA50, cyc + 2);
        step(1, 0, 1, 0, 64'hfA50, 1);
        idle(1, 1);
        idle(0, 1);
        idle(1, 1);

        // Stream of four back-to-back flits.
        for (int i = 0; i < 4; i++) begin
            push_exp(sv[i], cyc + 2);
            step(1, i % 2, 1, 0, sv[i], 1);
        end
        idle(0, 1);
        idle(1, 1);

        // Blocked read side holds its flit.
        step(1, 0, 1, 0, 64'hffffffff, 1);
        step(1, 1, 0, 1, '0, 1);
        step(1, 0, 0, 1, '0, 0);
        step(1, 1, 0, 1, '0, 1);
        step(1, 0, 0, 0, '0, 0);
        push_exp(64'hffffffff, cyc + 1);
        idle(1, 1);
        idle(0, 1);
        idle(1, 1);

        // Overflow: polarity held, second flit dropped.
        step(1, 0, 1, 0, 64'h1234, 1);
        step(1, 0, 1, 0, 64'hdead, 0);
        push_exp(64'h1234, cyc + 1);
        idle(1, 1);
        idle(0, 1);
        idle(1, 1);
        idle(0, 1);
        idle(1, 1);

        // Both buffers full, then a one-edge reset discards them.
        step(1, 0, 1, 1, 64'haaaa, 1);
        step(1, 1, 1, 1, 64'hbbbb, 1);
        step(0, 0, 0, 0, '0, -1);
        check_zero_out("midreset_data_out");
        idle(1, 1);
        idle(0, 1);
        idle(1, 1);
        idle(0, 1);
        idle(1, 1);

        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_left got=%0d exp=0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1);
    end

endmodule
